// File: rtl/io_dec_pkg.sv
// Shared types and widths for the 68k IO bus decoder.
// Channel index width is sized for the largest supported decoder (8 channels).
package io_dec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACK,
    NOMAP,
    ERR,
    FOREIGN
  } state_t;

  localparam int WS_W       = 4;
  localparam int TO_W       = 8;
  localparam int CH_FIELD_W = 12;
  localparam int MAX_CH     = 8;
  localparam int CH_IDX_W   = 3;

endpackage

// File: rtl/io_chan_match.sv
// Combinational address-window matcher: compares Address[15:4] against every
// channel base and reports the lowest-indexed hit as one-hot and as an index.
module io_chan_match
  import io_dec_pkg::*;
#(
  parameter int                             NUM_CH  = 4,
  parameter logic [NUM_CH*CH_FIELD_W-1:0]   CH_BASE = '0
) (
  input  logic [CH_FIELD_W-1:0] addr_field,
  output logic                  hit,
  output logic [NUM_CH-1:0]     match,
  output logic [CH_IDX_W-1:0]   ch_idx
);

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit    = 1'b0;
    match  = '0;
    ch_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (addr_field == CH_BASE[i*CH_FIELD_W +: CH_FIELD_W]) begin
        hit      = 1'b1;
        match    = '0;
        match[i] = 1'b1;
        ch_idx   = CH_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/io_bus_decoder_dtack.sv
// Registered IO bus decoder: per-channel enable/strobe, wait-stated DTACK_L,
// and a BERR_L timeout for IO accesses that hit no channel.
module io_bus_decoder_dtack
  import io_dec_pkg::*;
#(
  parameter int                           NUM_CH  = 4,
  parameter logic [NUM_CH*CH_FIELD_W-1:0] CH_BASE = {12'h803, 12'h801, 12'h800, 12'h802},
  parameter logic [NUM_CH*WS_W-1:0]       CH_WS   = {4'd0, 4'd0, 4'd0, 4'd2},
  parameter int                           TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Reset_L,
  input  logic [31:0]       Address,
  input  logic              IO_Select_H,
  input  logic              AS_L,
  output logic [NUM_CH-1:0] Enable_H,
  output logic [NUM_CH-1:0] Strobe_H,
  output logic              DTACK_L,
  output logic              BERR_L,
  output logic              Busy_H
);

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   enable_q, enable_d;
  logic [NUM_CH-1:0]   strobe_q, strobe_d;
  logic                dtack_l_q, dtack_l_d;
  logic                berr_l_q, berr_l_d;
  logic                busy_q, busy_d;
  logic [WS_W-1:0]     ws_cnt_q, ws_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                armed_q, armed_d;

  logic                hit;
  logic [NUM_CH-1:0]   match;
  logic [CH_IDX_W-1:0] ch_idx;
  logic [WS_W-1:0]     ws_load;

  logic                unused_addr_bits;
  assign unused_addr_bits = ^{Address[31:16], Address[3:0]};

  io_chan_match #(
    .NUM_CH  (NUM_CH),
    .CH_BASE (CH_BASE)
  ) u_match (
    .addr_field (Address[15:4]),
    .hit        (hit),
    .match      (match),
    .ch_idx     (ch_idx)
  );

  always_comb begin
    ws_load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == CH_IDX_W'(i)) ws_load = CH_WS[i*WS_W +: WS_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    enable_d  = enable_q;
    strobe_d  = '0;
    dtack_l_d = dtack_l_q;
    berr_l_d  = berr_l_q;
    ws_cnt_d  = ws_cnt_q;
    to_cnt_d  = to_cnt_q;
    // A cycle seen in flight at reset must end (AS_L high) before we accept another.
    armed_d   = armed_q | AS_L;

    if (state_q == IDLE) begin
      if (!AS_L && armed_q) begin
        if (!IO_Select_H) begin
          state_d = FOREIGN;
        end else if (hit) begin
          state_d  = WAIT;
          enable_d = match;
          strobe_d = match;
          ws_cnt_d = ws_load;
        end else begin
          state_d  = NOMAP;
          to_cnt_d = TO_W'(TIMEOUT);
        end
      end
    end else if (AS_L) begin
      // Release, and abort of an unfinished WAIT/NOMAP, share this path.
      state_d   = IDLE;
      enable_d  = '0;
      dtack_l_d = 1'b1;
      berr_l_d  = 1'b1;
    end else begin
      case (state_q)
        WAIT: begin
          if (ws_cnt_q != '0) begin
            ws_cnt_d = ws_cnt_q - 1'b1;
          end else begin
            dtack_l_d = 1'b0;
            state_d   = ACK;
          end
        end
        NOMAP: begin
          if (to_cnt_q != '0) begin
            to_cnt_d = to_cnt_q - 1'b1;
          end else begin
            berr_l_d = 1'b0;
            state_d  = ERR;
          end
        end
        ACK, ERR, FOREIGN: state_d = state_q;
        default:           state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_L) begin
      state_q   <= IDLE;
      enable_q  <= '0;
      strobe_q  <= '0;
      dtack_l_q <= 1'b1;
      berr_l_q  <= 1'b1;
      busy_q    <= 1'b0;
      ws_cnt_q  <= '0;
      to_cnt_q  <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      strobe_q  <= strobe_d;
      dtack_l_q <= dtack_l_d;
      berr_l_q  <= berr_l_d;
      busy_q    <= busy_d;
      ws_cnt_q  <= ws_cnt_d;
      to_cnt_q  <= to_cnt_d;
      armed_q   <= armed_d;
    end
  end

  assign Enable_H = enable_q;
  assign Strobe_H = strobe_q;
  assign DTACK_L  = dtack_l_q;
  assign BERR_L   = berr_l_q;
  assign Busy_H   = busy_q;

endmodule
